// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer.
// One 4-bit ripple-carry slice is reused over NIBBLES cycles, LSB nibble
// first, with a carry register chaining consecutive nibbles. Operands are
// taken over a valid/ready handshake and the result is offered on a second
// valid/ready handshake.

// 4-bit ripple-carry slice: s = a + b + c, with carry-out.
module nibble_serial_adder_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] carry;

  // Explicit ripple chain, bit by bit.
  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = c_i;
    for (int unsigned i = 0; i < 4; i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (a_i[i] & carry[i]) | (b_i[i] & carry[i]);
    end
    c_o = carry[4];
  end

endmodule

module nibble_serial_adder_ctrl #(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] beff_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             amsb_q;
  logic             bmsb_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       slice_s;
  logic             slice_c;
  logic             last_nib;
  logic [WIDTH-1:0] b_eff;

  assign b_eff    = sub ? ~b : b;
  assign last_nib = (cnt_q == CW'(NIBBLES - 1));

  // Select the operand nibbles addressed by the counter.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = beff_q[4*i +: 4];
      end
    end
  end

  nibble_serial_adder_slice u_slice (
    .a_i (a_nib),
    .b_i (b_nib),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      beff_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      amsb_q      <= 1'b0;
      bmsb_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            beff_q     <= b_eff;
            carry_q    <= sub ? 1'b1 : cin;
            cnt_q      <= '0;
            amsb_q     <= a[WIDTH-1];
            bmsb_q     <= b_eff[WIDTH-1];
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end

        RUN: begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CW'(i)) begin
              sum_q[4*i +: 4] <= slice_s;
            end
          end
          carry_q <= slice_c;
          if (last_nib) begin
            cnt_q       <= '0;
            cout_q      <= slice_c;
            ovf_q       <= (amsb_q == bmsb_q) && (slice_s[3] != amsb_q);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          cnt_q       <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (NIBBLES=4): a transaction-level model
// checked every cycle, directed literal vectors, and randomized traffic.
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: edges left until the result appears, and the result itself.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_sum = '0;
  logic         p_cout = 1'b0;
  logic         p_ovf = 1'b0;
  logic [W-1:0] m_be;
  logic [W:0]   m_t;
  int           ops_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done = 1'b0;
        ops_done++;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_sum  = p_sum;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
    end else if (in_valid) begin
      m_be   = sub ? ~b : b;
      m_t    = {1'b0, a} + {1'b0, m_be} + ((sub ? 1'b1 : cin) ? 17'd1 : 17'd0);
      p_sum  = m_t[W-1:0];
      p_cout = m_t[W];
      p_ovf  = (a[W-1] == m_be[W-1]) && (m_t[W-1] != a[W-1]);
      m_left = N;
    end
  end

  // Every-cycle comparison; result fields are meaningful only outside RUN.
  always @(negedge clk) begin
    chk("in_ready", in_ready, (!m_done && m_left == 0));
    chk("out_valid", out_valid, m_done);
    chk("busy", busy, (m_done || m_left > 0));
    if (m_left == 0) begin
      chk("sum", sum, m_sum);
      chk("cout", cout, m_cout);
      chk("overflow", overflow, m_ovf);
    end
  end

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom % 8)
      0: v = 16'h0000;
      1: v = 16'hFFFF;
      2: v = 16'h7FFF;
      3: v = 16'h8000;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input logic [W-1:0] es, input logic ec,
                        input logic eo, input string nm);
    int n;
    n = 0;
    @(posedge clk); #2;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      chk({nm, " in_ready run"}, in_ready, 1'b0);
      @(posedge clk); #2;
      n++;
    end
    chk({nm, " latency"}, n, N - 1 + 1);
    chk({nm, " in_ready done"}, in_ready, 1'b0);
    chk({nm, " sum"}, sum, es);
    chk({nm, " cout"}, cout, ec);
    chk({nm, " overflow"}, overflow, eo);
    @(posedge clk); #2;
    chk({nm, " back to idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset sum", sum, 16'h0000);
    chk("reset cout/ovf", {cout, overflow}, 2'b00);
    #9 rst_n = 1'b1;

    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "add1");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "addripple");
    run_op(16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "addcin");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "addovf");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "subovf");
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "subneg");
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, "subpos");

    // Backpressure with operand pulses while the result is held.
    begin
      int n;
      n = 0;
      @(posedge clk); #2;
      a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #2;
      in_valid = 1'b0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #2;
        n++;
      end
      chk("bp latency", n, 4);
      for (int i = 0; i < 6; i++) begin
        in_valid = i[0];
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        @(posedge clk); #2;
        chk("bp hold", {out_valid, in_ready, sum, cout, overflow}, {2'b10, 16'h2345, 2'b00});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #2;
      chk("bp release", {out_valid, in_ready, busy}, 3'b010);
    end
    run_op(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "after bp");

    // Reset in the middle of RUN.
    @(posedge clk); #2;
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst outputs", {in_ready, out_valid, busy, cout, overflow}, 5'b10000);
    chk("midrst sum", sum, 16'h0000);
    repeat (3) begin
      @(posedge clk); #2;
      chk("midrst no out_valid", out_valid, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post rst in_ready", in_ready, 1'b1);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "post rst add");

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      in_valid  = ($urandom % 3) != 0;
      a         = pick();
      b         = pick();
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (N + 3) @(posedge clk);
    #2;
    chk("random ops completed", (ops_done > 50), 1'b1);
    chk("final idle", {in_ready, busy}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
